module_2: RTL and testbench
===========================

// Module: module_2
// PURPOSE
//  Consumer stage of the ping-pong dataflow toy; sits directly downstream of module_1.
//  Once module_1 has filled B and C, this stage reads both arrays element by element.
//  For each element it writes D[i] = B[i] + C[i] and accumulates the running total.
//  The total is presented on ap_return; block-level handshake is ap_ctrl_chain.
// PARAMETERS
//  N   5   elements per invocation (loop trip count), 1..2**AW-1
//  AW  3   array address width
//  DW  32  data width of B, C, D and ap_return
// PORTS
//  ap_clk       in   1   clock, all state on rising edge
//  ap_rst       in   1   synchronous reset, active-high
//  ap_start     in   1   start request, level-sensitive
//  ap_done      out  1   invocation complete (combinational pulse or held by ap_done_reg)
//  ap_continue  in   1   downstream acknowledges done, clears held done
//  ap_idle      out  1   FSM in S1 and ap_start low
//  ap_ready     out  1   ready for new inputs (same cycle as the completion pulse)
//  B_address0   out  AW  B read address
//  B_ce0        out  1   B read enable
//  B_q0         in   DW  B read data, valid 1 cycle after B_ce0
//  C_address0   out  AW  C read address
//  C_ce0        out  1   C read enable
//  C_q0         in   DW  C read data, valid 1 cycle after C_ce0
//  D_address0   out  AW  D write address
//  D_ce0        out  1   D enable
//  D_we0        out  1   D write enable
//  D_d0         out  DW  D write data
//  ap_return    out  DW  sum of all D values written in the last invocation
// BEHAVIOUR
//  - One-hot FSM, 3 states: S1 (idle/accept), S2 (loop test + read issue), S3 (write).
//  - Reset (ap_rst=1 at posedge) sets:
//    - FSM=S1, ap_done_reg=0, acc=0, i=0.
//    - All ce/we outputs 0, ap_done=0, ap_ready=0; ap_idle=1 if ap_start=0.
//  - S1: start is accepted when ap_start=1 and ap_done_reg=0.
//    - On accept: i<=0, acc<=0, go S2. Otherwise stay in S1.
//    - A start arriving while ap_done_reg=1 is ignored until ap_continue clears it.
//  - S2 with i==N: ap_done=1 and ap_ready=1 for that cycle, then go S1.
//    - If ap_continue=0 in that cycle, ap_done_reg<=1.
//  - S2 with i<N:
//    - B_ce0=C_ce0=1 and B_address0=C_address0=i[AW-1:0].
//    - addr_r<=i, i_nxt<=i+1, go S3.
//  - S3:
//    - D_ce0=D_we0=1, D_address0=addr_r, D_d0=B_q0+C_q0 truncated to DW (wrap, no saturation).
//    - acc<=acc+D_d0 mod 2^DW; i<=i_nxt; go S2.
//  - ap_return = acc register; stable from the done cycle until the next start is accepted.
//  - ap_done = (S2 & i==N) | ap_done_reg.
//  - ap_done_reg is cleared by ap_continue=1 in any state; ap_continue wins over a same-cycle set.
//  - Latency: done asserts 2N+1 cycles after the accept cycle (N=5: 11). Next accept is possible
//    the cycle after done if ap_continue=1 on the done cycle.
//  - B/C ce are never asserted in S1 or S3; D we is only asserted in S3.
//  - Reset mid-loop aborts the invocation: no further D write, no done pulse, acc=0.
//  - The counter is AW+1 bits wide so that i==N is reachable without wrap.
// TESTING
//  1. B={9,18,27,36,45}, C={2,4,6,8,10}, start pulse, ap_continue=1
//     -> D={11,22,33,44,55} at addr 0..4; ap_return=165; done 11 cycles after accept.
//  2. Same data, ap_continue=0 held
//     -> ap_done stays 1; a new ap_start is ignored (FSM stays S1, no ce);
//        ap_continue=1 -> done drops next cycle, then start is accepted.
//  3. B[i]=C[i]=32'h8000_0000 for all i
//     -> every D=0 (wrap); ap_return=0.
//  4. ap_rst=1 asserted in S3 of element 2
//     -> next cycle FSM=S1, all ce/we=0, ap_done=0, ap_idle=1 (ap_start low); D[2] not written.
//  5. Two back-to-back invocations with ap_start held high and ap_continue=1
//     -> second accept in the cycle after done; ap_return restarts from 0.
//  6. Idle check: ap_start=0 after reset -> ap_idle=1, no ce/we, ap_done=0 for 20 cycles.

Source files
------------

// File: rtl/module_2.sv
// rtl/module_2.sv - ping-pong consumer: D[i] = B[i] + C[i] with running total on ap_return
module module_2 #(
    parameter int N  = 5,
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          ap_start,
    output logic          ap_done,
    input  logic          ap_continue,
    output logic          ap_idle,
    output logic          ap_ready,
    output logic [AW-1:0] B_address0,
    output logic          B_ce0,
    input  logic [DW-1:0] B_q0,
    output logic [AW-1:0] C_address0,
    output logic          C_ce0,
    input  logic [DW-1:0] C_q0,
    output logic [AW-1:0] D_address0,
    output logic          D_ce0,
    output logic          D_we0,
    output logic [DW-1:0] D_d0,
    output logic [DW-1:0] ap_return
);

    typedef enum logic [2:0] {
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b100
    } state_t;

    // One extra counter bit so i can reach N without wrapping.
    localparam logic [AW:0] TRIP = (AW+1)'(N);

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   i;
    logic [AW:0]   i_nxt;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] acc;
    logic          ap_done_reg;

    logic          accept;
    logic          loop_end;
    logic          loop_body;
    logic [DW-1:0] sum_d;

    assign accept    = (state == S1) && ap_start && !ap_done_reg;
    assign loop_end  = (state == S2) && (i == TRIP);
    assign loop_body = (state == S2) && (i != TRIP);
    assign sum_d     = B_q0 + C_q0;

    assign ap_return  = acc;
    assign B_address0 = i[AW-1:0];
    assign C_address0 = i[AW-1:0];
    assign D_address0 = addr_r;
    assign D_d0       = sum_d;

    // Memory strobes are masked by reset so an aborted loop cannot land a write on the reset edge.
    always_comb begin
        state_nxt = state;
        ap_done   = ap_done_reg;
        ap_ready  = 1'b0;
        ap_idle   = 1'b0;
        B_ce0     = 1'b0;
        C_ce0     = 1'b0;
        D_ce0     = 1'b0;
        D_we0     = 1'b0;
        case (state)
            S1: begin
                ap_idle = !ap_start;
                if (accept) begin
                    state_nxt = S2;
                end
            end
            S2: begin
                if (loop_end) begin
                    ap_done   = 1'b1;
                    ap_ready  = 1'b1;
                    state_nxt = S1;
                end else begin
                    B_ce0     = !ap_rst;
                    C_ce0     = !ap_rst;
                    state_nxt = S3;
                end
            end
            S3: begin
                D_ce0     = !ap_rst;
                D_we0     = !ap_rst;
                state_nxt = S2;
            end
            default: state_nxt = S1;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= S1;
            ap_done_reg <= 1'b0;
            acc         <= '0;
            i           <= '0;
            i_nxt       <= '0;
            addr_r      <= '0;
        end else begin
            state <= state_nxt;
            if (ap_continue) begin
                ap_done_reg <= 1'b0;
            end else if (loop_end) begin
                ap_done_reg <= 1'b1;
            end
            if (accept) begin
                i   <= '0;
                acc <= '0;
            end
            if (loop_body) begin
                addr_r <= i[AW-1:0];
                i_nxt  <= i + 1'b1;
            end
            if (state == S3) begin
                acc <= acc + sum_d;
                i   <= i_nxt;
            end
        end
    end

endmodule

// File: tb/tb_module_2.sv
// tb/tb_module_2.sv - self-checking bench for module_2 with B/C ROM and D write-capture models
module tb_module_2;

    localparam int N  = 5;
    localparam int AW = 3;
    localparam int DW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          ap_start;
    logic          ap_done;
    logic          ap_continue;
    logic          ap_idle;
    logic          ap_ready;
    logic [AW-1:0] B_address0;
    logic          B_ce0;
    logic [DW-1:0] B_q0;
    logic [AW-1:0] C_address0;
    logic          C_ce0;
    logic [DW-1:0] C_q0;
    logic [AW-1:0] D_address0;
    logic          D_ce0;
    logic          D_we0;
    logic [DW-1:0] D_d0;
    logic [DW-1:0] ap_return;

    module_2 #(.N(N), .AW(AW), .DW(DW)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .B_address0  (B_address0),
        .B_ce0       (B_ce0),
        .B_q0        (B_q0),
        .C_address0  (C_address0),
        .C_ce0       (C_ce0),
        .C_q0        (C_q0),
        .D_address0  (D_address0),
        .D_ce0       (D_ce0),
        .D_we0       (D_we0),
        .D_d0        (D_d0),
        .ap_return   (ap_return)
    );

    always #5 ap_clk = ~ap_clk;

    logic [DW-1:0] B_mem [8];
    logic [DW-1:0] C_mem [8];
    int            wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];

    always @(posedge ap_clk) begin
        if (B_ce0) B_q0 <= B_mem[B_address0];
        if (C_ce0) C_q0 <= C_mem[C_address0];
        if (D_ce0 && D_we0) begin
            wr_addr_q.push_back(int'(D_address0));
            wr_data_q.push_back(D_d0);
        end
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0][31:0] b;
        logic [4:0][31:0] c;
        logic [31:0]      exp_sum;
    } vec_t;

    vec_t tbl [5];

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [4:0][31:0] b, input logic [4:0][31:0] c);
        for (int k = 0; k < 8; k++) begin
            B_mem[k] = (k < N) ? b[k] : 32'h0;
            C_mem[k] = (k < N) ? c[k] : 32'h0;
        end
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    function automatic logic [31:0] model_sum();
        logic [31:0] s = 32'h0;
        for (int k = 0; k < N; k++) s = s + B_mem[k] + C_mem[k];
        return s;
    endfunction

    task automatic check_writes(input string nm);
        logic [31:0] e;
        chk({nm, "_wr_count"}, wr_addr_q.size(), N);
        for (int k = 0; k < N && k < wr_addr_q.size(); k++) begin
            e = B_mem[k] + C_mem[k];
            chk({nm, "_wr_addr"}, wr_addr_q[k], k);
            chk({nm, "_wr_data"}, wr_data_q[k], e);
        end
    endtask

    task automatic run_inv(input logic cont, input logic hold, output int lat);
        ap_continue = cont;
        ap_start    = 1'b1;
        lat         = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (!hold) ap_start = 1'b0;
            if (ap_done) break;
        end
        if (!ap_done) chk("done_timeout", ap_done, 1'b1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (ap_done) break;
        end
        if (!ap_done) chk("done_timeout", ap_done, 1'b1);
    endtask

    initial begin
        int               lat;
        logic             bad;
        logic [4:0][31:0] rb;
        logic [4:0][31:0] rc;

        tbl[0].b = {32'd45, 32'd36, 32'd27, 32'd18, 32'd9};
        tbl[0].c = {32'd10, 32'd8, 32'd6, 32'd4, 32'd2};
        tbl[0].exp_sum = 32'd165;
        tbl[1].b = {5{32'h8000_0000}};
        tbl[1].c = {5{32'h8000_0000}};
        tbl[1].exp_sum = 32'd0;
        tbl[2].b = {5{32'hFFFF_FFFF}};
        tbl[2].c = {5{32'd2}};
        tbl[2].exp_sum = 32'd5;
        tbl[3].b = {5{32'h7FFF_FFFF}};
        tbl[3].c = {5{32'd0}};
        tbl[3].exp_sum = 32'h7FFF_FFFB;
        tbl[4].b = {5{32'd0}};
        tbl[4].c = {5{32'd0}};
        tbl[4].exp_sum = 32'd0;

        ap_rst = 1'b1;
        ap_start = 1'b0;
        ap_continue = 1'b0;
        for (int k = 0; k < 8; k++) begin
            B_mem[k] = 32'h0;
            C_mem[k] = 32'h0;
        end
        repeat (3) tick();
        ap_rst = 1'b0;
        #1;

        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_done", ap_done, 1'b0);
        chk("rst_ready", ap_ready, 1'b0);
        chk("rst_ces", {B_ce0, C_ce0, D_ce0, D_we0}, 4'b0);
        chk("rst_return", ap_return, 32'h0);

        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!ap_idle || ap_done || ap_ready || B_ce0 || C_ce0 || D_ce0 || D_we0) bad = 1'b1;
        end
        chk("idle_20", bad, 1'b0);

        for (int t = 0; t < 5; t++) begin
            load(tbl[t].b, tbl[t].c);
            run_inv(1'b1, 1'b0, lat);
            chk($sformatf("tbl%0d_latency", t), lat, 11);
            chk($sformatf("tbl%0d_ready", t), ap_ready, 1'b1);
            chk($sformatf("tbl%0d_return", t), ap_return, tbl[t].exp_sum);
            check_writes($sformatf("tbl%0d", t));
            tick();
            chk($sformatf("tbl%0d_done_drop", t), ap_done, 1'b0);
            chk($sformatf("tbl%0d_idle", t), ap_idle, 1'b1);
            chk($sformatf("tbl%0d_ret_hold", t), ap_return, tbl[t].exp_sum);
        end

        load(tbl[0].b, tbl[0].c);
        run_inv(1'b0, 1'b0, lat);
        chk("hold_latency", lat, 11);
        chk("hold_return", ap_return, 32'd165);
        ap_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_done_stays", ap_done, 1'b1);
            chk("hold_no_ce", B_ce0, 1'b0);
            chk("hold_return_stable", ap_return, 32'd165);
        end
        ap_continue = 1'b1;
        tick();
        chk("cont_done_drop", ap_done, 1'b0);
        chk("cont_no_accept_yet", B_ce0, 1'b0);
        wr_addr_q.delete();
        wr_data_q.delete();
        tick();
        chk("cont_accept", B_ce0, 1'b1);
        ap_start = 1'b0;
        wait_done(lat);
        chk("cont_latency", lat, 10);
        chk("cont_return", ap_return, 32'd165);
        check_writes("cont");
        tick();

        load(tbl[0].b, tbl[0].c);
        ap_continue = 1'b1;
        ap_start = 1'b1;
        lat = 0;
        while (lat < 100) begin
            tick();
            lat++;
            ap_start = 1'b0;
            if (D_we0 && D_address0 == 3'd2) break;
        end
        chk("rst_mid_reach", {D_we0, D_address0}, {1'b1, 3'd2});
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        #1;
        chk("rst_mid_ces", {B_ce0, C_ce0, D_ce0, D_we0}, 4'b0);
        chk("rst_mid_done", ap_done, 1'b0);
        chk("rst_mid_idle", ap_idle, 1'b1);
        chk("rst_mid_return", ap_return, 32'h0);
        chk("rst_mid_writes", wr_addr_q.size(), 2);
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (ap_done || D_we0) bad = 1'b1;
        end
        chk("rst_mid_quiet", bad, 1'b0);

        load(tbl[0].b, tbl[0].c);
        run_inv(1'b1, 1'b1, lat);
        chk("b2b_latency1", lat, 11);
        chk("b2b_return1", ap_return, 32'd165);
        check_writes("b2b1");
        load(tbl[2].b, tbl[2].c);
        tick();
        chk("b2b_gap_ce", B_ce0, 1'b0);
        chk("b2b_gap_done", ap_done, 1'b0);
        chk("b2b_gap_idle", ap_idle, 1'b0);
        tick();
        chk("b2b_accept_ce", B_ce0, 1'b1);
        chk("b2b_accept_addr", B_address0, 3'd0);
        chk("b2b_acc_restart", ap_return, 32'h0);
        ap_start = 1'b0;
        wait_done(lat);
        chk("b2b_latency2", lat, 10);
        chk("b2b_return2", ap_return, 32'd5);
        check_writes("b2b2");
        tick();

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) begin
                rb[k] = $urandom;
                rc[k] = (r % 4 == 0) ? ~rb[k] + 32'd1 + 32'($urandom_range(3)) : $urandom;
            end
            load(rb, rc);
            run_inv(1'b1, 1'b0, lat);
            chk("rnd_latency", lat, 11);
            chk("rnd_return", ap_return, model_sum());
            check_writes("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
